// File: rtl/sdram_uart_pkg.sv
// Shared types and defaults for the SDRAM-to-UART burst transmitter.
package sdram_uart_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   typedef enum logic [2:0] {PH_IDLE, PH_START, PH_DATA, PH_PARITY, PH_STOP} phase_t;
   localparam int DEFAULT_BAUD_DIV = 5208;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational (first-word-fall-through) read port.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              do_wr, do_rd;

   assign full    = (level == DEPTH_L);
   assign empty   = (level == '0);
   assign do_rd   = rd_en && !empty;
   // When full, the slot being written is the one being read out this cycle.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_wr, do_rd})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/sdram_uart_burst_tx.sv
// Pulls a burst of words from an upstream FIFO into a local buffer and
// streams them out as back-to-back UART frames.
module sdram_uart_burst_tx
   import sdram_uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 1024,
   parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [$clog2(DEPTH):0] src_level,
   input  logic [$clog2(DEPTH):0] burst_len,
   output logic                   src_rd_en,
   input  logic [DATA_W-1:0]      src_data,
   output logic                   uart_txd,
   output logic                   busy,
   output logic                   burst_done,
   output logic                   cfg_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int CW = $clog2(DATA_W);
   localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE       = (AW+1)'(1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV-1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W-1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS-1);

   state_t            state, state_nx;
   logic [AW:0]       blen_q, fetch_cnt, sent_cnt;
   logic              wr_q, cfg_set, legal, start;
   logic [DATA_W-1:0] f_data;
   logic              f_full, f_empty, pop;
   logic [AW:0]       f_level;

   phase_t            phase;
   logic [BW-1:0]     baud_cnt;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit, bit_end, frame_end;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
      .clk(clk), .rst(rst),
      .wr_en(wr_q), .wr_data(src_data),
      .rd_en(pop), .rd_data(f_data),
      .full(f_full), .empty(f_empty), .level(f_level)
   );

   assign legal     = (burst_len != '0) && (burst_len <= DEPTH_L);
   assign start     = legal && (src_level >= burst_len) && (f_level == '0);
   assign busy      = (state != IDLE);
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign frame_end = (phase == PH_STOP) && bit_end && (bit_cnt == STOP_LAST);
   // Popping on the final stop cycle gives gap-free back-to-back frames.
   assign pop       = ((phase == PH_IDLE) || frame_end) && !f_empty;

   always_comb begin
      state_nx   = state;
      src_rd_en  = 1'b0;
      burst_done = 1'b0;
      cfg_set    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = FETCH;
            else if (!legal && src_level != '0) cfg_set = 1'b1;
         end
         FETCH: begin
            src_rd_en = 1'b1;
            if (fetch_cnt == blen_q - ONE) state_nx = DRAIN;
         end
         DRAIN: begin
            if (frame_end && sent_cnt == blen_q - ONE) begin
               burst_done = 1'b1;
               state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         blen_q    <= '0;
         fetch_cnt <= '0;
         sent_cnt  <= '0;
         wr_q      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         wr_q      <= src_rd_en;
         fetch_cnt <= (state == FETCH) ? fetch_cnt + ONE : '0;
         if (cfg_set) cfg_err <= 1'b1;
         if (state == IDLE && start) blen_q <= burst_len;
         if (burst_done)     sent_cnt <= '0;
         else if (frame_end) sent_cnt <= sent_cnt + ONE;
      end
   end

   always_comb begin
      uart_txd = 1'b1;
      case (phase)
         PH_START:  uart_txd = 1'b0;
         PH_DATA:   uart_txd = shreg[0];
         PH_PARITY: uart_txd = par_bit;
         default:   uart_txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    <= PH_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else if (pop) begin
         phase    <= PH_START;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= f_data;
         par_bit  <= (^f_data) ^ (PARITY_ODD != 0);
      end else if (phase != PH_IDLE) begin
         baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
         if (bit_end) begin
            case (phase)
               PH_START: begin
                  phase   <= PH_DATA;
                  bit_cnt <= '0;
               end
               PH_DATA: begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     phase   <= (PARITY_EN != 0) ? PH_PARITY : PH_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               PH_PARITY: begin
                  phase   <= PH_STOP;
                  bit_cnt <= '0;
               end
               PH_STOP: begin
                  if (bit_cnt == STOP_LAST) phase <= PH_IDLE;
                  else bit_cnt <= bit_cnt + CW'(1);
               end
               default: phase <= PH_IDLE;
            endcase
         end
      end
   end

   // The start guard keeps the buffer from ever being written while full
   // unless a word leaves in the same cycle.
   assert property (@(posedge clk) disable iff (rst) !(f_full && wr_q && !pop));
endmodule

// File: tb/tb_sdram_uart_burst_tx.sv
// Directed bench: four DUT configurations driven one at a time from one sequence.
module tb_sdram_uart_burst_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] lvl [4];
   logic [4:0] blen;
   logic [7:0] src_data = 8'h00;
   wire  [3:0] rd, txd, busy, done, cfg;

   logic [7:0] mem [64];
   logic [5:0] ptr = 6'd0;
   logic [5:0] wp  = 6'd0;
   int         rc [4] = '{default: 0};
   int         dc [4] = '{default: 0};
   int         n_ass = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   sdram_uart_burst_tx #(.DATA_W(8), .DEPTH(16), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .src_level(lvl[0]), .burst_len(blen), .src_rd_en(rd[0]), .src_data(src_data),
      .uart_txd(txd[0]), .busy(busy[0]), .burst_done(done[0]), .cfg_err(cfg[0]));
   sdram_uart_burst_tx #(.DATA_W(8), .DEPTH(16), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .src_level(lvl[1]), .burst_len(blen), .src_rd_en(rd[1]), .src_data(src_data),
      .uart_txd(txd[1]), .busy(busy[1]), .burst_done(done[1]), .cfg_err(cfg[1]));
   sdram_uart_burst_tx #(.DATA_W(8), .DEPTH(16), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .src_level(lvl[2]), .burst_len(blen), .src_rd_en(rd[2]), .src_data(src_data),
      .uart_txd(txd[2]), .busy(busy[2]), .burst_done(done[2]), .cfg_err(cfg[2]));
   sdram_uart_burst_tx #(.DATA_W(8), .DEPTH(16), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .src_level(lvl[3]), .burst_len(blen), .src_rd_en(rd[3]), .src_data(src_data),
      .uart_txd(txd[3]), .busy(busy[3]), .burst_done(done[3]), .cfg_err(cfg[3]));

   // Upstream FIFO model: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (|rd) begin
         src_data <= mem[ptr];
         ptr      <= ptr + 6'd1;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd[i])   rc[i] <= rc[i] + 1;
         if (done[i]) dc[i] <= dc[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_ass++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] b);
      mem[wp] = b;
      wp = wp + 6'd1;
   endtask

   // Waits (bounded) for a start bit, then checks every cycle of the frame.
   task automatic frame(input int u, input logic [7:0] d, input int pe, input logic par,
                        input int stops, input bit last, output int g);
      logic [11:0] fb;
      int nb;
      nb = 9 + pe + stops;
      fb = '1;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1+i] = d[i];
      if (pe != 0) fb[9] = par;
      g = 0;
      while (txd[u] !== 1'b0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      chk($sformatf("start_found_u%0d_%02h", u, d), {31'b0, g < 400}, 32'd1);
      for (int c = 0; c < nb*4; c++) begin
         chk($sformatf("txd_u%0d_%02h_c%0d", u, d, c), {31'b0, txd[u]}, {31'b0, fb[c/4]});
         chk($sformatf("done_u%0d_%02h_c%0d", u, d, c), {31'b0, done[u]}, {31'b0, last && c == nb*4-1});
         @(negedge clk);
      end
   endtask

   initial begin
      int g, r0, d0;
      logic [7:0]  t16 [16];
      logic [15:0] par16;
      t16 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
              8'hAA, 8'h55, 8'h80, 8'hC1, 8'h5A, 8'hE7, 8'h10, 8'h00};
      par16 = 16'b0100_1100_0101_0101;
      for (int i = 0; i < 4; i++) lvl[i] = 5'd0;
      blen = 5'd4;
      repeat (3) @(negedge clk);
      chk("reset_txd",  {28'b0, txd},  32'hF);
      chk("reset_busy", {28'b0, busy}, 32'h0);
      chk("reset_done", {28'b0, done}, 32'h0);
      chk("reset_cfg",  {28'b0, cfg},  32'h0);
      chk("reset_rd",   {28'b0, rd},   32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Level below burst length holds off; reaching it starts next cycle.
      load(8'h55); load(8'hA3); load(8'h00); load(8'hFF);
      lvl[0] = 5'd3;
      repeat (6) @(negedge clk);
      chk("short_level_rd",   {31'b0, rd[0]},   32'd0);
      chk("short_level_busy", {31'b0, busy[0]}, 32'd0);
      r0 = rc[0];
      d0 = dc[0];
      lvl[0] = 5'd4;
      @(negedge clk);
      chk("start_rd",   {31'b0, rd[0]},   32'd1);
      chk("start_busy", {31'b0, busy[0]}, 32'd1);
      lvl[0] = 5'd0;
      frame(0, 8'h55, 0, 1'b0, 1, 1'b0, g);
      chk("first_start_latency", g, 32'd3);
      frame(0, 8'hA3, 0, 1'b0, 1, 1'b0, g);
      chk("gap_f2", g, 32'd0);
      frame(0, 8'h00, 0, 1'b0, 1, 1'b0, g);
      chk("gap_f3", g, 32'd0);
      frame(0, 8'hFF, 0, 1'b0, 1, 1'b1, g);
      chk("gap_f4", g, 32'd0);
      chk("burst4_busy_after", {31'b0, busy[0]}, 32'd0);
      chk("burst4_rd_cycles",  rc[0] - r0, 32'd4);
      chk("burst4_done_count", dc[0] - d0, 32'd1);

      // Parity: 0xA3 has four ones -> even parity 0, odd parity 1.
      blen = 5'd1;
      load(8'hA3);
      lvl[1] = 5'd1;
      @(negedge clk);
      lvl[1] = 5'd0;
      frame(1, 8'hA3, 1, 1'b0, 1, 1'b1, g);
      chk("even_par_latency", g, 32'd3);
      chk("even_par_idle_after", {31'b0, txd[1]}, 32'd1);
      chk("even_par_busy_after", {31'b0, busy[1]}, 32'd0);
      load(8'hA3);
      lvl[2] = 5'd1;
      @(negedge clk);
      lvl[2] = 5'd0;
      frame(2, 8'hA3, 1, 1'b1, 1, 1'b1, g);
      chk("odd_par_idle_after", {31'b0, txd[2]}, 32'd1);
      chk("odd_par_busy_after", {31'b0, busy[2]}, 32'd0);

      // Illegal burst lengths set the sticky error and never fetch.
      r0 = rc[0];
      blen = 5'd0;
      lvl[0] = 5'd16;
      repeat (3) @(negedge clk);
      chk("blen0_cfg",  {31'b0, cfg[0]},  32'd1);
      chk("blen0_rd",   {31'b0, rd[0]},   32'd0);
      chk("blen0_busy", {31'b0, busy[0]}, 32'd0);
      rst = 1'b1;
      #1;
      chk("cfg_cleared_by_rst", {31'b0, cfg[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      blen = 5'd17;
      repeat (3) @(negedge clk);
      chk("blen17_cfg", {31'b0, cfg[0]}, 32'd1);
      chk("blen17_no_fetch", rc[0] - r0, 32'd0);
      lvl[0] = 5'd0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full-depth burst, parity + 2 stop bits: 48-cycle frames, no gaps.
      for (int k = 0; k < 16; k++) load(t16[k]);
      d0 = dc[3];
      blen = 5'd16;
      lvl[3] = 5'd16;
      @(negedge clk);
      lvl[3] = 5'd0;
      for (int k = 0; k < 16; k++) begin
         frame(3, t16[k], 1, par16[k], 2, k == 15, g);
         if (k > 0) chk($sformatf("gap16_f%0d", k), g, 32'd0);
      end
      chk("burst16_busy_after", {31'b0, busy[3]}, 32'd0);
      chk("burst16_done_count", dc[3] - d0, 32'd1);

      // Reset during data bit 3 of frame 2 (0x81 bit 3 is 0).
      load(8'h3C); load(8'h81); load(8'h7E); load(8'h12);
      blen = 5'd4;
      lvl[0] = 5'd4;
      @(negedge clk);
      lvl[0] = 5'd0;
      frame(0, 8'h3C, 0, 1'b0, 1, 1'b0, g);
      g = 0;
      while (txd[0] !== 1'b0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      chk("f2_start_gap", g, 32'd0);
      repeat (17) @(negedge clk);
      chk("pre_rst_bit3", {31'b0, txd[0]}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_txd",  {31'b0, txd[0]},  32'd1);
      chk("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
      chk("mid_rst_rd",   {31'b0, rd[0]},   32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_idle_c%0d", k), {30'b0, busy[0], txd[0]}, 32'd1);
      end
      blen = 5'd1;
      load(8'h96);
      lvl[0] = 5'd1;
      @(negedge clk);
      lvl[0] = 5'd0;
      frame(0, 8'h96, 0, 1'b0, 1, 1'b1, g);
      chk("post_rst_fresh_latency", g, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
      $finish;
   end
endmodule
